// File: rtl/bayer_pkg.sv
// Shared Bayer colour-filter-array definitions, used by both the mosaicer and
// the demosaicer so that pixel-type codes always agree between the two.
package bayer_pkg;

    typedef logic [1:0] pixel_type_t;

    localparam pixel_type_t PIX_R   = 2'b00;
    localparam pixel_type_t PIX_G_R = 2'b01;
    localparam pixel_type_t PIX_G_B = 2'b10;
    localparam pixel_type_t PIX_B   = 2'b11;

    // The 2x2 CFA tile repeats, so only the position LSBs matter. Flipping x
    // swaps R<->G_R and G_B<->B; flipping y swaps R<->G_B and G_R<->B.
    function automatic pixel_type_t bayer_type(input pixel_type_t pattern,
                                               input logic        x_lsb,
                                               input logic        y_lsb);
        return pattern ^ {y_lsb, x_lsb};
    endfunction

endpackage

// File: rtl/bayer_position_counter.sv
// Raster position tracker for a pixel stream: x/y counters with line/frame
// wrap, start-of-frame resynchronisation and framing-error detection.
module bayer_position_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic          clk_pixel,
    input  logic          reset_n,
    input  logic          accept,
    input  logic          sof,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic          frame_error
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    logic          synced;
    logic          at_origin;
    logic          err_next;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        pos_x  = x_cnt;
        pos_y  = y_cnt;
        x_next = x_cnt;
        y_next = y_cnt;

        if (sof) begin
            pos_x = '0;
            pos_y = '0;
        end

        if (pos_x == X_LAST) begin
            x_next = '0;
            y_next = (pos_y == Y_LAST) ? '0 : pos_y + 1'b1;
        end else begin
            x_next = pos_x + 1'b1;
            y_next = pos_y;
        end

        // A misplaced sof and a missing sof are both errors; the first beat
        // after reset defines the frame origin and is never flagged.
        at_origin = (x_cnt == '0) && (y_cnt == '0);
        err_next  = accept && synced && (sof ^ at_origin);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            synced      <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= err_next;
            if (accept) begin
                x_cnt  <= x_next;
                y_cnt  <= y_next;
                synced <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bayer_mosaic_stream.sv
// Streaming RGB-to-Bayer mosaicer: one RGB pixel in, the single CFA sample a
// sensor would see at that raster position out, with type and frame markers.
module bayer_mosaic_stream
    import bayer_pkg::*;
#(
    parameter int          WIDTH         = 640,
    parameter int          HEIGHT        = 480,
    parameter int          BIT_WIDTH     = 8,
    parameter pixel_type_t BAYER_PATTERN = PIX_R
) (
    input  logic                   clk_pixel,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3*BIT_WIDTH-1:0] in_rgb,
    input  logic                   in_sof,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIT_WIDTH-1:0]   out_raw,
    output logic [1:0]             out_pixel_type,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   out_eof,
    output logic                   frame_error
);

    localparam int            XW     = $clog2(WIDTH);
    localparam int            YW     = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic                 accept;
    logic [XW-1:0]        pos_x;
    logic [YW-1:0]        pos_y;
    pixel_type_t          beat_type;
    logic [BIT_WIDTH-1:0] chan_r;
    logic [BIT_WIDTH-1:0] chan_g;
    logic [BIT_WIDTH-1:0] chan_b;
    logic [BIT_WIDTH-1:0] raw_sel;
    logic                 beat_eol;

    // Single output register: a new beat may enter whenever the slot is
    // empty or is being drained this same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign chan_r = in_rgb[3*BIT_WIDTH-1 -: BIT_WIDTH];
    assign chan_g = in_rgb[2*BIT_WIDTH-1 -: BIT_WIDTH];
    assign chan_b = in_rgb[BIT_WIDTH-1:0];

    bayer_position_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_position (
        .clk_pixel   (clk_pixel),
        .reset_n     (reset_n),
        .accept      (accept),
        .sof         (in_sof),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .frame_error (frame_error)
    );

    always_comb begin
        beat_type = bayer_type(BAYER_PATTERN, pos_x[0], pos_y[0]);
        beat_eol  = (pos_x == X_LAST);
        raw_sel   = chan_g;
        unique case (beat_type)
            PIX_R:   raw_sel = chan_r;
            PIX_B:   raw_sel = chan_b;
            default: raw_sel = chan_g;
        endcase
    end

    // NOTE: the data fields are reset along with out_valid; it is a single
    // register, and a defined post-reset value keeps the output bus clean.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            out_raw        <= '0;
            out_pixel_type <= PIX_R;
            out_sof        <= 1'b0;
            out_eol        <= 1'b0;
            out_eof        <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_raw        <= raw_sel;
            out_pixel_type <= beat_type;
            out_sof        <= (pos_x == '0) && (pos_y == '0);
            out_eol        <= beat_eol;
            out_eof        <= beat_eol && (pos_y == Y_LAST);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/bayer_mosaic_stream.md
Name: bayer_mosaic_stream

Overview:
Streaming RGB-to-Bayer mosaicer: the inverse of malvar_he_cutler_demosaic. It accepts one full RGB pixel per beat in raster order and emits the single Bayer sample a colour-filter-array sensor would have produced at that position, plus the 2-bit pixel type. Used to synthesise raw sensor frames from RGB test images, and in loopback with the demosaicer for gray-preservation checks.

Parameters:
WIDTH, 640, active pixels per line (>=2, even)
HEIGHT, 480, active lines per frame (>=2, even)
BIT_WIDTH, 8, bits per colour channel
BAYER_PATTERN, 2'b00, pixel type at (x=0,y=0); codes come from the shared package

Ports:
clk_pixel  input  1  pixel clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  in_rgb/in_sof valid this cycle
in_ready  output  1  block accepts the beat when in_valid && in_ready
in_rgb  input  3*BIT_WIDTH  {R,G,B}, R in the MSBs (same packing as center_pixel_rgb)
in_sof  input  1  first pixel of a frame
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_raw  output  BIT_WIDTH  selected Bayer sample
out_pixel_type  output  2  type of out_raw's position
out_sof  output  1  output beat is pixel (0,0)
out_eol  output  1  output beat is x=WIDTH-1
out_eof  output  1  output beat is (WIDTH-1,HEIGHT-1)
frame_error  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset: reset_n=0 clears all state asynchronously. out_valid=0, out_raw=0, out_pixel_type=0, out_sof/out_eol/out_eof=0, frame_error=0, x=0, y=0, in_ready=1 after reset.
- Reset mid-frame: a buffered beat is dropped. The counters restart at (0,0). The next accepted beat is treated as pixel (0,0) whether or not in_sof is set.
- Handshake: single output register.
  - in_ready = !out_valid || out_ready (combinational).
  - An accepted beat loads the output register on the next edge. Latency is 1 cycle; full throughput is 1 pixel per clock.
  - Output fields are stable while out_valid && !out_ready.
  - out_valid clears on a consume when no new beat is accepted in the same cycle. A simultaneous consume and accept reloads the register with out_valid held at 1.
- Position counters x (clog2 WIDTH bits) and y (clog2 HEIGHT bits) advance only on accepted beats:
  - x = WIDTH-1 wraps x to 0 and increments y.
  - x = WIDTH-1 with y = HEIGHT-1 wraps to (0,0).
- in_sof resync: an accepted beat with in_sof=1 is taken as position (0,0). The counters become (1,0) after it.
  - If the expected position was not (0,0), frame_error pulses one cycle after the accept.
  - frame_error also pulses when (0,0) is expected and in_sof=0. That beat is still processed as (0,0).
- Pixel type = BAYER_PATTERN XOR {y[0], x[0]}, computed at the accepted beat's position.
- Channel select:
  - PIX_R (00): R
  - PIX_G_R (01) and PIX_G_B (10): G
  - PIX_B (11): B
  - out_raw is the selected channel unmodified; there is no rounding or scaling.
- Markers are registered with out_raw, from the beat's position:
  - out_sof = (x==0 && y==0)
  - out_eol = (x==WIDTH-1)
  - out_eof = out_eol && y==HEIGHT-1
- Backpressure never loses or duplicates a pixel. An input beat offered while in_ready=0 is not accepted and the counters hold.

Decomposition:
- Shared package bayer_pkg:
  - pixel-type typedef and constants PIX_R=2'b00, PIX_G_R=2'b01, PIX_G_B=2'b10, PIX_B=2'b11
  - function bayer_type(pattern, x_lsb, y_lsb)
  - this package is also imported by malvar_he_cutler_demosaic
- One sub-module, bayer_position_counter: x/y counters, wrap logic, sof resync and error detection. Channel select and the output register stay in the top level.

Test Plan:
- Gray: WIDTH=4, HEIGHT=2, every in_rgb=24'hABABAB, out_ready=1 -> 8 beats of out_raw=8'hAB; types 00,01,00,01,10,11,10,11; out_sof on beat 0; out_eol on beats 3 and 7; out_eof on beat 7.
- Channel select: in_rgb=24'h112233 for a full 4x2 frame, BAYER_PATTERN=00 -> out_raw sequence 11,22,11,22,22,33,22,33. With BAYER_PATTERN=2'b11 the sequence is 33,22,33,22,22,11,22,11.
- Backpressure: drop out_ready for 3 cycles mid-line with in_valid=1 -> in_ready=0 for those cycles, output held stable, no skipped or repeated pixel (check with an incrementing R channel 0..7).
- Early sof: in_sof=1 on beat 5 of a 4x2 frame -> frame_error pulses once; that beat is out_sof=1, type=BAYER_PATTERN; the counters continue from (1,0).
- Reset mid-frame: assert reset_n=0 asynchronously between edges after 3 beats -> out_valid drops immediately. After release, the next beat has out_sof=1 and frame_error=0 whether in_sof is 1 or 0.
- Loopback: feed a 5x5 window of mosaic output from a constant 24'hABABAB frame into malvar_he_cutler_demosaic with the matching center type -> center_pixel_rgb=24'hABABAB for all four types.
